led_array_arbiter: RTL and testbench

Shares the board LED_ARRAY_IO bank between the HPS PIO (default owner) and two fabric requesters, such as PLL-lock and heartbeat status logic. A minimum-hold, round-robin arbiter selects the owner. A PWM stage then dims the selected pattern with a glitch-free, period-aligned duty update. It sits in the top level between the Qsys LED PIO export and the LED pins, replacing ad-hoc OR-ing of fabric status onto individual LEDs.

---
 rtl/led_array_arbiter_if.sv | 10 +
 rtl/led_array_arbiter.sv | 64 ++++++
 tb/tb_led_array_arbiter.sv | 84 ++++++++
 3 files changed

// File: rtl/led_array_arbiter_if.sv
// led_array_arbiter_if: fabric request/pattern bus and ownership status for the LED bank arbiter
interface led_array_arbiter_if;
  logic [1:0] req;
  logic [7:0] pattern0;
  logic [7:0] pattern1;
  logic [1:0] grant;
  logic [1:0] owner;
  modport master (output req, pattern0, pattern1, input grant, owner);
  modport slave  (input req, pattern0, pattern1, output grant, owner);
endinterface

// File: rtl/led_array_arbiter.sv
// led_array_arbiter: minimum-hold round-robin owner of the LED bank with period-aligned PWM dimming
module led_array_arbiter #(
  parameter int PWM_PERIOD  = 10000,
  parameter int DUTY_W      = 14,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic              CLOCK50,
  input  logic              reset,
  input  logic [7:0]        hps_led,
  input  logic [DUTY_W-1:0] duty,
  led_array_arbiter_if.slave bus,
  output logic [7:0]        led_out,
  output logic              pwm_tick
);
  localparam logic [1:0] S_HPS = 2'b00, S_REQ0 = 2'b01, S_REQ1 = 2'b10;
  localparam int PW = PWM_PERIOD > 1 ? $clog2(PWM_PERIOD) : 1;
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [PW-1:0] P_MAX = PW'(PWM_PERIOD - 1);
  localparam logic [HW-1:0] H_MAX = HW'(HOLD_CYCLES - 1);
  logic [1:0] state, state_nx;
  logic last, cur, pick, nxt, sw, hold_done, wrap, pwm_on;
  logic [HW-1:0] hold_cnt;
  logic [PW-1:0] pwm_cnt;
  logic [DUTY_W-1:0] duty_lat;
  logic [7:0] lat0, lat1, sel;
  assign bus.grant = state;
  assign bus.owner = state;
  assign cur       = state[1];
  assign hold_done = hold_cnt == H_MAX;
  assign pick      = &bus.req ? ~last : bus.req[1];
  assign wrap      = pwm_cnt == P_MAX;
  assign pwm_on    = DUTY_W'(pwm_cnt) < duty_lat;
  assign pwm_tick  = wrap & ~reset;
  // sw marks a new grant: from HPS on any request, or a handover once the hold has expired
  always_comb begin
    sw       = state == S_HPS ? |bus.req : hold_done & bus.req[~cur];
    nxt      = state == S_HPS ? pick : ~cur;
    state_nx = sw ? (nxt ? S_REQ1 : S_REQ0)
             : (state != S_HPS && hold_done && !bus.req[cur]) ? S_HPS : state;
    sel      = state == S_REQ0 ? (bus.req[0] ? bus.pattern0 : lat0)
             : state == S_REQ1 ? (bus.req[1] ? bus.pattern1 : lat1) : hps_led;
  end
  always_ff @(posedge CLOCK50) begin
    if (reset) begin
      state    <= S_HPS;
      last     <= 1'b1;
      hold_cnt <= '0;
      pwm_cnt  <= '0;
      duty_lat <= DUTY_W'(PWM_PERIOD);
      lat0     <= '0;
      lat1     <= '0;
      led_out  <= '0;
    end else begin
      state    <= state_nx;
      if (sw) last <= nxt;
      hold_cnt <= sw ? '0 : hold_done ? hold_cnt : hold_cnt + 1'b1;
      pwm_cnt  <= wrap ? '0 : pwm_cnt + 1'b1;
      if (wrap) duty_lat <= duty;
      if (bus.req[0]) lat0 <= bus.pattern0;
      if (bus.req[1]) lat1 <= bus.pattern1;
      led_out  <= sel & {8{pwm_on}};
    end
  end
endmodule

// File: tb/tb_led_array_arbiter.sv
// tb_led_array_arbiter: table-driven PWM checks and scripted arbitration sequences, scoreboard compared after each edge
module tb_led_array_arbiter;
  logic CLOCK50, reset, pwm_tick;
  logic [7:0] hps_led, led_out;
  logic [3:0] duty;
  int checks = 0, errors = 0;
  typedef struct { logic [1:0] g; logic [7:0] led; logic tick; bit ct; string nm; } exp_t;
  typedef struct { int n; logic [3:0] duty; logic [7:0] led; logic tick; } vec_t;
  exp_t q[$];
  exp_t m;
  vec_t tbl[23];
  led_array_arbiter_if bus();
  led_array_arbiter #(.PWM_PERIOD(10), .DUTY_W(4), .HOLD_CYCLES(20)) dut (
    .CLOCK50(CLOCK50), .reset(reset), .hps_led(hps_led), .duty(duty),
    .bus(bus), .led_out(led_out), .pwm_tick(pwm_tick));
  initial begin
    CLOCK50 = 0;
    forever #5 CLOCK50 = ~CLOCK50;
  end
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step(input logic rs, input logic [1:0] r, input logic [7:0] p0, input logic [3:0] d,
                      input logic [1:0] g, input logic [7:0] led, input logic tk, input bit ct, input string nm);
    exp_t e;
    @(negedge CLOCK50);
    reset = rs;
    bus.req = r;
    bus.pattern0 = p0;
    duty = d;
    e.g = g; e.led = led; e.tick = tk; e.ct = ct; e.nm = nm;
    q.push_back(e);
  endtask
  always @(posedge CLOCK50) begin
    #1;
    if (q.size() > 0) begin
      m = q.pop_front();
      chk({m.nm, " grant"}, {6'd0, bus.grant}, {6'd0, m.g});
      chk({m.nm, " owner"}, {6'd0, bus.owner}, {6'd0, m.g});
      chk({m.nm, " led"}, led_out, m.led);
      if (m.ct) chk({m.nm, " tick"}, {7'd0, pwm_tick}, {7'd0, m.tick});
    end
  end
  initial begin
    reset = 1; bus.req = 0; bus.pattern0 = 8'h0F; bus.pattern1 = 8'hF0; hps_led = 8'hA5; duty = 4'd10;
    tbl[0]  = '{8, 4'd10, 8'hA5, 1'b0};  tbl[1]  = '{1, 4'd10, 8'hA5, 1'b1};
    tbl[2]  = '{9, 4'd10, 8'hA5, 1'b0};  tbl[3]  = '{1, 4'd10, 8'hA5, 1'b1};
    tbl[4]  = '{5, 4'd10, 8'hA5, 1'b0};  tbl[5]  = '{4, 4'd3,  8'hA5, 1'b0};
    tbl[6]  = '{1, 4'd3,  8'hA5, 1'b1};  tbl[7]  = '{4, 4'd3,  8'hA5, 1'b0};
    tbl[8]  = '{5, 4'd3,  8'h00, 1'b0};  tbl[9]  = '{1, 4'd3,  8'h00, 1'b1};
    tbl[10] = '{1, 4'd3,  8'h00, 1'b0};  tbl[11] = '{3, 4'd3,  8'hA5, 1'b0};
    tbl[12] = '{2, 4'd3,  8'h00, 1'b0};  tbl[13] = '{3, 4'd0,  8'h00, 1'b0};
    tbl[14] = '{1, 4'd0,  8'h00, 1'b1};  tbl[15] = '{1, 4'd0,  8'h00, 1'b0};
    tbl[16] = '{5, 4'd0,  8'h00, 1'b0};  tbl[17] = '{3, 4'd15, 8'h00, 1'b0};
    tbl[18] = '{1, 4'd15, 8'h00, 1'b1};  tbl[19] = '{1, 4'd15, 8'h00, 1'b0};
    tbl[20] = '{8, 4'd15, 8'hA5, 1'b0};  tbl[21] = '{1, 4'd15, 8'hA5, 1'b1};
    tbl[22] = '{1, 4'd15, 8'hA5, 1'b0};
    repeat (2) step(1, 2'b00, 8'h0F, 4'd10, 2'b00, 8'h00, 1'b0, 1, "reset");
    foreach (tbl[i])
      for (int k = 0; k < tbl[i].n; k++)
        step(0, 2'b00, 8'h0F, tbl[i].duty, 2'b00, tbl[i].led, tbl[i].tick, 1, "pwm");
    for (int i = 0; i < 62; i++)
      step(0, i < 43 ? 2'b11 : 2'b00, 8'h0F, 4'd15,
           i < 20 ? 2'b01 : i < 40 ? 2'b10 : i < 60 ? 2'b01 : 2'b00,
           i == 0 ? 8'hA5 : i <= 20 ? 8'h0F : i <= 40 ? 8'hF0 : i <= 60 ? 8'h0F : 8'hA5, 1'b0, 0, "rr");
    for (int i = 0; i < 32; i++)
      step(0, i < 30 ? 2'b01 : 2'b00, 8'h0F, 4'd15, i < 30 ? 2'b01 : 2'b00,
           (i == 0 || i == 31) ? 8'hA5 : 8'h0F, 1'b0, 0, "keep");
    for (int i = 0; i < 22; i++)
      step(0, i < 2 ? 2'b01 : 2'b00, i < 2 ? 8'h0F : 8'h3C, 4'd15, i < 20 ? 2'b01 : 2'b00,
           (i == 0 || i == 21) ? 8'hA5 : 8'h0F, 1'b0, 0, "short");
    for (int i = 0; i < 31; i++)
      step(i == 8, i < 10 ? 2'b01 : 2'b00, 8'h0F, 4'd15, i == 8 ? 2'b00 : i < 29 ? 2'b01 : 2'b00,
           i == 0 ? 8'hA5 : i == 8 ? 8'h00 : i == 9 ? 8'hA5 : i <= 29 ? 8'h0F : 8'hA5,
           1'b0, i == 8, "rst");
    repeat (2) @(negedge CLOCK50);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
